// File: rtl/n4_b10_up_counter.sv
// n4_b10_up_counter -- four-digit BCD up-counter.
//
// The counter is a chain of four one-digit base-10 cells. Each digit's carry
// feeds the enable of the next digit, and the top digit's carry leaves the
// block as eu. To build a wider decimal counter, connect eu of one block to
// m_ei of the next block.
//
// A parallel load replaces any digit greater than 9 with 0. It also sets the
// sticky err flag, which only reset clears.
//
// Build option: N4_B10_UP_COUNTER_SATURATE_EN
//   defined   -> at 9999 with m_ei=1 the count holds at 9999 (eu still asserts)
//   undefined -> the count wraps from 9999 to 0000

module n4_b10_digit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ei,
    input  logic       hold,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       eu,
    output logic       bad
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // Flag a load digit that is not valid BCD.
    always_comb begin
        bad = (d > 4'd9) ? 1'b1 : 1'b0;
    end

    // Carry out is combinational, so a chain of cells ripples within one cycle.
    always_comb begin
        eu = ei & ((digit_q == 4'd9) ? 1'b1 : 1'b0);
    end

    // Next digit value: load has priority over count, and a count past 9 wraps to 0.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            if (bad) begin
                digit_d = 4'd0;
            end else begin
                digit_d = d;
            end
        end else if (ei && !hold) begin
            if (digit_q >= 4'd9) begin
                digit_d = 4'd0;
            end else begin
                digit_d = digit_q + 4'd1;
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q = digit_q;

endmodule

module n4_b10_up_counter (
    input  logic        m_clock,
    input  logic        m_reset_,
    input  logic        m_ei,
    input  logic        m_load,
    input  logic [15:0] d15_d0,
    output logic [15:0] q15_q0,
    output logic        eu,
    output logic        err
);

    logic       eu0_s;
    logic       eu1_s;
    logic       eu2_s;
    logic       eu3_s;
    logic [3:0] bad_s;
    logic       hold_s;
    logic       err_q;
    logic       err_d;

    // Saturating build: freeze every digit once the whole count reads 9999 and
    // is enabled. eu3_s is exactly that condition.
    always_comb begin
`ifdef N4_B10_UP_COUNTER_SATURATE_EN
        hold_s = eu3_s;
`else
        hold_s = 1'b0;
`endif
    end

    n4_b10_digit u_dig0 (
        .clk   (m_clock),
        .rst_n (m_reset_),
        .ei    (m_ei),
        .hold  (hold_s),
        .load  (m_load),
        .d     (d15_d0[3:0]),
        .q     (q15_q0[3:0]),
        .eu    (eu0_s),
        .bad   (bad_s[0])
    );

    n4_b10_digit u_dig1 (
        .clk   (m_clock),
        .rst_n (m_reset_),
        .ei    (eu0_s),
        .hold  (hold_s),
        .load  (m_load),
        .d     (d15_d0[7:4]),
        .q     (q15_q0[7:4]),
        .eu    (eu1_s),
        .bad   (bad_s[1])
    );

    n4_b10_digit u_dig2 (
        .clk   (m_clock),
        .rst_n (m_reset_),
        .ei    (eu1_s),
        .hold  (hold_s),
        .load  (m_load),
        .d     (d15_d0[11:8]),
        .q     (q15_q0[11:8]),
        .eu    (eu2_s),
        .bad   (bad_s[2])
    );

    n4_b10_digit u_dig3 (
        .clk   (m_clock),
        .rst_n (m_reset_),
        .ei    (eu2_s),
        .hold  (hold_s),
        .load  (m_load),
        .d     (d15_d0[15:12]),
        .q     (q15_q0[15:12]),
        .eu    (eu3_s),
        .bad   (bad_s[3])
    );

    // Sticky error: set by any load containing an invalid digit, cleared only by reset.
    always_comb begin
        if (m_load && (bad_s != 4'b0000)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register with synchronous active-low reset.
    always_ff @(posedge m_clock) begin
        if (!m_reset_) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign eu  = eu3_s;
    assign err = err_q;

endmodule

// File: tb/tb_n4_b10_up_counter.sv
// Self-checking bench for n4_b10_up_counter. A decimal reference model pushes
// the expected post-edge state into a queue as each cycle is driven. Each test
// task pops that expectation after the edge and compares it inline.

module tb_n4_b10_up_counter;

    logic        m_clock;
    logic        m_reset_;
    logic        m_ei;
    logic        m_load;
    logic [15:0] d15_d0;
    logic [15:0] q15_q0;
    logic        eu;
    logic        err;

    typedef struct {
        logic [15:0] q;
        logic        err;
        logic        eu;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] mdl_q;
    logic        mdl_err;
    int          n_run;
    int          n_fail;

    n4_b10_up_counter dut (
        .m_clock  (m_clock),
        .m_reset_ (m_reset_),
        .m_ei     (m_ei),
        .m_load   (m_load),
        .d15_d0   (d15_d0),
        .q15_q0   (q15_q0),
        .eu       (eu),
        .err      (err)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        int n;
        logic [15:0] r;
        n = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
`ifdef N4_B10_UP_COUNTER_SATURATE_EN
        if (n == 9999) return v;
`endif
        n = (n + 1) % 10000;
        r[15:12] = 4'(n / 1000);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    // Drive one cycle at the falling edge, update the model, push the expectation, then step past the rising edge.
    task automatic cycle(input logic rst_i, input logic ei_i, input logic load_i, input logic [15:0] d_i);
        exp_t x;
        logic [3:0] nib;
        @(negedge m_clock);
        m_reset_ = rst_i;
        m_ei     = ei_i;
        m_load   = load_i;
        d15_d0   = d_i;
        if (!rst_i) begin
            mdl_q   = 16'h0000;
            mdl_err = 1'b0;
        end else if (load_i) begin
            for (int k = 0; k < 4; k++) begin
                nib = d_i[k*4 +: 4];
                if (nib > 4'd9) begin
                    nib     = 4'd0;
                    mdl_err = 1'b1;
                end
                mdl_q[k*4 +: 4] = nib;
            end
        end else if (ei_i) begin
            mdl_q = bcd_inc(mdl_q);
        end
        x.q   = mdl_q;
        x.err = mdl_err;
        x.eu  = ei_i && (mdl_q == 16'h9999);
        sb.push_back(x);
        @(posedge m_clock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, (i == 2) ? 1'b1 : 1'b0, 1'b0, 16'h0000);
            e = sb.pop_front();
            n_run++;
            if (q15_q0 !== e.q || err !== e.err || eu !== e.eu) begin
                n_fail++;
                $display("FAIL reset: got q=%h err=%b eu=%b want q=%h err=%b eu=%b", q15_q0, err, eu, e.q, e.err, e.eu);
            end
        end
    endtask

    task automatic test_count12();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 16'h0000);
            e = sb.pop_front();
            n_run++;
            if (q15_q0 !== e.q || err !== e.err || eu !== e.eu) begin
                n_fail++;
                $display("FAIL count12[%0d]: got q=%h err=%b eu=%b want q=%h err=%b eu=%b", i, q15_q0, err, eu, e.q, e.err, e.eu);
            end
        end
        n_run++;
        if (q15_q0 !== 16'h0012) begin
            n_fail++;
            $display("FAIL count12_final: got q=%h want q=0012", q15_q0);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 16'hFFFF);
            e = sb.pop_front();
            n_run++;
            if (q15_q0 !== e.q || err !== e.err || eu !== e.eu) begin
                n_fail++;
                $display("FAIL hold[%0d]: got q=%h err=%b eu=%b want q=%h err=%b eu=%b", i, q15_q0, err, eu, e.q, e.err, e.eu);
            end
        end
    endtask

    task automatic test_carry();
        cycle(1'b1, 1'b0, 1'b1, 16'h0199);
        cycle(1'b1, 1'b1, 1'b0, 16'h0000);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (sb.size() == 0) begin
                n_run++;
                if (q15_q0 !== e.q || q15_q0 !== 16'h0200 || eu !== 1'b0) begin
                    n_fail++;
                    $display("FAIL carry: got q=%h eu=%b want q=%h eu=0", q15_q0, eu, e.q);
                end
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) cycle(1'b1, 1'b1, 1'b1, 16'h9999);
            else if (i == 1) cycle(1'b1, 1'b1, 1'b0, 16'h0000);
            else cycle(1'b1, 1'b0, 1'b0, 16'h0000);
            e = sb.pop_front();
            n_run++;
            if (q15_q0 !== e.q || err !== e.err || eu !== e.eu) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got q=%h err=%b eu=%b want q=%h err=%b eu=%b", i, q15_q0, err, eu, e.q, e.err, e.eu);
            end
        end
    endtask

    task automatic test_load_priority();
        cycle(1'b1, 1'b1, 1'b1, 16'h1234);
        e = sb.pop_front();
        n_run++;
        if (q15_q0 !== e.q || q15_q0 !== 16'h1234) begin
            n_fail++;
            $display("FAIL load_priority: got q=%h want q=%h", q15_q0, e.q);
        end
    endtask

    task automatic test_err();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: cycle(1'b1, 1'b0, 1'b1, 16'h1A3F);
                1: cycle(1'b1, 1'b0, 1'b1, 16'h0005);
                2: cycle(1'b0, 1'b1, 1'b0, 16'h0000);
                default: cycle(1'b1, 1'b1, 1'b0, 16'h0000);
            endcase
            e = sb.pop_front();
            n_run++;
            if (q15_q0 !== e.q || err !== e.err || eu !== e.eu) begin
                n_fail++;
                $display("FAIL err_seq[%0d]: got q=%h err=%b eu=%b want q=%h err=%b eu=%b", i, q15_q0, err, eu, e.q, e.err, e.eu);
            end
        end
    endtask

    task automatic test_reset_vs_load();
        cycle(1'b1, 1'b0, 1'b1, 16'h0777);
        cycle(1'b0, 1'b1, 1'b1, 16'h4321);
        void'(sb.pop_front());
        e = sb.pop_front();
        n_run++;
        if (q15_q0 !== e.q || q15_q0 !== 16'h0000 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vs_load: got q=%h err=%b want q=0000 err=0", q15_q0, err);
        end
    endtask

    task automatic test_random();
        logic [15:0] dv;
        for (int i = 0; i < 300; i++) begin
            dv = 16'($urandom);
            if ($urandom_range(0, 3) == 0) dv = 16'h9998;
            cycle(($urandom_range(0, 40) == 0) ? 1'b0 : 1'b1, 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, dv);
            e = sb.pop_front();
            n_run++;
            if (q15_q0 !== e.q || err !== e.err || eu !== e.eu) begin
                n_fail++;
                $display("FAIL random[%0d]: got q=%h err=%b eu=%b want q=%h err=%b eu=%b", i, q15_q0, err, eu, e.q, e.err, e.eu);
            end
        end
    endtask

    initial begin
        n_run    = 0;
        n_fail   = 0;
        mdl_q    = 16'h0000;
        mdl_err  = 1'b0;
        m_reset_ = 1'b0;
        m_ei     = 1'b0;
        m_load   = 1'b0;
        d15_d0   = 16'h0000;
        test_reset();
        test_count12();
        test_hold();
        test_carry();
        test_wrap();
        test_load_priority();
        test_err();
        test_reset_vs_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/n4_b10_up_counter.md
N4_B10_UP_COUNTER -- requirements
Module: n4_b10_up_counter

Interface
REQ-001 The block SHALL use one clock and one synchronous, active-low reset:
- m_clock, input, 1 bit: sole clock; all state updates on its rising edge.
- m_reset_, input, 1 bit: synchronous, active-low reset.
REQ-002 The block SHALL expose these further ports:
- m_ei, input, 1 bit: count enable (carry-in from the preceding stage).
- m_load, input, 1 bit: parallel-load strobe.
- d15_d0, input, 16 bits: load value, four BCD digits, d15_d12 the most significant.
- q15_q0, output, 16 bits: registered count, four BCD digits, q3_q0 the least significant digit.
- eu, output, 1 bit: carry-out, used as the enable of a following stage.
- err, output, 1 bit: sticky flag for an invalid BCD load.
REQ-003 The block SHALL be built as a chain of four one-digit base-10 up-counter cells, each with its own ei/eu, mirroring the base-2 down-counter chain.

Function
REQ-004 Each digit SHALL hold a value in 0..9 at all times after reset.
REQ-005 When m_ei=1 and m_load=0, the count SHALL increment by one in decimal on the next edge.
- Latency is one cycle.
- A digit at 9 with its ei=1 SHALL wrap to 0 and assert its eu.
REQ-006 Digit carry out SHALL be combinational: eu_k = ei_k AND (digit_k == 9), and eu = eu of digit 3.
- eu therefore equals m_ei AND (q15_q0 == 9999 in BCD).
REQ-007 When m_ei=0 and m_load=0, q15_q0 SHALL hold its value.
REQ-008 When m_load=1, d15_d0 SHALL be loaded on the next edge regardless of m_ei.
- Load has priority over count; there is no increment in that cycle.
REQ-009 On load, any input digit greater than 9 SHALL be stored as 0, and err SHALL be set on the same edge.
- Valid digits in the same load are stored unchanged.
REQ-010 err SHALL remain 1 until reset; a later valid load SHALL NOT clear it.
REQ-011 eu SHALL be evaluated from the registered count and m_ei only, never from d15_d0 or m_load.
REQ-012 Chaining blocks via eu to m_ei SHALL produce an 8-digit decimal counter with no extra logic.

Reset
REQ-013 When m_reset_=0 at a rising edge of m_clock, the next state SHALL be q15_q0=0000 (BCD) and err=0.
- Reset has priority over m_load and m_ei.
REQ-014 After reset, eu SHALL read 0 for every value of m_ei, since the count is 0000.
REQ-015 Reset asserted mid-count SHALL abort the count with no partial increment.
- The first count after m_reset_ returns to 1 SHALL go 0000 to 0001.

Configuration
REQ-016 The macro N4_B10_UP_COUNTER_SATURATE_EN SHALL control wrap behaviour at 9999.
- Defined: at 9999 with m_ei=1 the counter holds 9999 instead of wrapping, and eu still asserts per REQ-006.
- Undefined: the counter wraps 9999 to 0000 as in REQ-005.
- m_load behaviour is identical in both builds.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset then m_ei=1 for 12 cycles -> q15_q0 = 0012 BCD (0x0012); eu=0 throughout.
- Load 0x0199, then m_ei=1 for 1 cycle -> 0x0200; no eu.
- Load 0x9999, m_ei=1 -> eu=1 in the load-following cycle. Next edge gives 0x0000 without the macro, 0x9999 with it.
- m_load=1 and m_ei=1 together with d=0x1234 -> q=0x1234, not 0x1235.
- Load 0x1A3F -> q=0x1030 and err=1. Then load 0x0005 -> err still 1. Then m_reset_=0 for one edge -> q=0x0000, err=0.
- m_reset_=0 in the same cycle as m_load=1 with d=0x4321 -> q=0x0000.
